switch_input_fifo: RTL and testbench

Parametrised input-capture block for the CPU I/O subsystem. Synchronises and debounces the raw `valid` push-button and the `in` switch bus, and turns each debounced press into one captured sample. Samples are queued in a small FIFO that the CPU drains through a memory-mapped read port. Compared with the current single-register input path, it adds configurable data width, queue depth and debounce length, plus full/empty/count status and a sticky overflow flag.

---
 rtl/switch_input_fifo.sv | 123 ++++++++++++
 tb/tb_switch_input_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_fifo.sv
// switch_input_fifo
//   Synchronises and debounces a raw push-button (valid) and switch bus (in),
//   turns each debounced press into one captured sample and queues samples
//   in a small first-word-fall-through FIFO drained by the CPU.
//
// Parameters
//   DATA_W     : width of the switch bus and of each queued sample
//   DEPTH      : FIFO entries (power of two, >= 2)
//   DEB_CYCLES : consecutive mismatching cycles before the debounced level flips
//
// Ports
//   clk      in  : system clock, rising edge
//   rst      in  : asynchronous active-high reset
//   valid    in  : raw push-button (asynchronous)
//   in       in  : raw switch data (asynchronous)
//   rd_en    in  : pop one entry when non-empty
//   clr_ovf  in  : clear the sticky overflow flag
//   rd_data  out : head entry, 0 while empty
//   empty    out : no entries stored
//   full     out : DEPTH entries stored
//   count    out : number of stored entries
//   overflow out : sticky, a press was dropped on a full FIFO
module switch_input_fifo #(
  parameter int DATA_W     = 5,
  parameter int DEPTH      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [DATA_W-1:0]        in,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(DEPTH);

  logic              v_s1, v_s2;
  logic [DATA_W-1:0] d_s1, d_s2;
  logic              deb, deb_q;
  logic [CW-1:0]     cnt;
  logic              push;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic              do_push, do_pop;

  // Synchroniser, debouncer and edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s1  <= 1'b0;
      v_s2  <= 1'b0;
      d_s1  <= '0;
      d_s2  <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      v_s1  <= valid;
      v_s2  <= v_s1;
      d_s1  <= in;
      d_s2  <= d_s1;
      deb_q <= deb;
      if (v_s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= v_s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign push = deb & ~deb_q;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // on the same edge; wptr == rptr then, and the head is read out before the
  // overwrite lands.
  assign do_push = push & (~full | rd_en);
  assign do_pop  = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop) begin
        count <= count + (PW + 1)'(1);
      end else if (!do_push && do_pop) begin
        count <= count - (PW + 1)'(1);
      end
      // Set wins over clear.
      if (push && full && !rd_en) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= d_s2;
  end

  assign rd_data = empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_switch_input_fifo.sv
// Self-checking bench for switch_input_fifo: directed vectors and sequences
// with hand-derived expectations, then randomized stimulus compared against
// a queue-based behavioural reference model.
module tb_switch_input_fifo;

  localparam int W   = 5;
  localparam int D   = 4;
  localparam int DEB = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid;
  logic [W-1:0]         din;
  logic                 rd_en;
  logic                 clr_ovf;
  logic [W-1:0]         rd_data;
  logic                 empty;
  logic                 full;
  logic [$clog2(D):0]   count;
  logic                 overflow;

  int nerr = 0;
  int nchk = 0;

  switch_input_fifo #(
    .DATA_W    (W),
    .DEPTH     (D),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .in      (din),
    .rd_en   (rd_en),
    .clr_ovf (clr_ovf),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // Two-stage delay lines for the raw inputs, a window of the last DEB
  // synchronised samples for debouncing, and a plain queue for the FIFO.
  bit           m_s1, m_s2, m_deb, m_debq, m_ovf;
  logic [W-1:0] m_d1, m_d2;
  bit           hist[$];
  logic [W-1:0] mq[$];
  bit           m_push, m_was_full, m_all;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_debq = 0; m_ovf = 0;
      m_d1 = '0; m_d2 = '0;
      hist.delete();
      mq.delete();
    end else begin
      m_push     = m_deb && !m_debq;
      m_was_full = (mq.size() == D);
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      if (m_push && (!m_was_full || rd_en)) mq.push_back(m_d2);
      if (m_push && m_was_full && !rd_en) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_debq = m_deb;
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        m_all = 1;
        foreach (hist[i]) if (hist[i] == m_deb) m_all = 0;
        if (m_all) m_deb = !m_deb;
      end
      m_s2 = m_s1;
      m_s1 = valid;
      m_d2 = m_d1;
      m_d1 = din;
    end
  end

  // -------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input bit e, input bit f,
                         input bit o, input logic [W-1:0] r);
    chk($sformatf("%s_count", tag), 32'(count), 32'(c));
    chk($sformatf("%s_empty", tag), 32'(empty), 32'(e));
    chk($sformatf("%s_full", tag), 32'(full), 32'(f));
    chk($sformatf("%s_overflow", tag), 32'(overflow), 32'(o));
    chk($sformatf("%s_rd_data", tag), 32'(rd_data), 32'(r));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [W-1:0] d);
    din = d; valid = 1'b1;
    cyc(8);
    valid = 1'b0;
    cyc(8);
  endtask

  task automatic pop1();
    rd_en = 1'b1; cyc(1);
    rd_en = 1'b0; cyc(1);
  endtask

  task automatic clr1();
    clr_ovf = 1'b1; cyc(1);
    clr_ovf = 1'b0; cyc(1);
  endtask

  // ---------------------------------------------------------------- table
  typedef enum {OP_PRESS, OP_POP, OP_CLR} op_e;
  typedef struct {
    op_e          op;
    logic [W-1:0] data;
    int           c;
    bit           f;
    bit           o;
    logic [W-1:0] r;
  } vec_t;

  function automatic vec_t mk(op_e op, logic [W-1:0] data, int c, bit f, bit o,
                              logic [W-1:0] r);
    vec_t v;
    v.op = op; v.data = data; v.c = c; v.f = f; v.o = o; v.r = r;
    return v;
  endfunction

  vec_t vt[$];
  bit   pat[8];
  logic [W-1:0] heads[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; valid = 1'b0; din = '0; rd_en = 1'b0; clr_ovf = 1'b0;

    // Reset pulse: outputs clear asynchronously.
    #1 rst = 1'b1;
    #1 chk_all("reset", 0, 1, 0, 0, '0);
    @(negedge clk) rst = 1'b0;

    // Single press: count rises exactly 6 edges after E0.
    din = 5'b00100; valid = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("press_lat_E%0d", k), 32'(count), (k >= 6) ? 32'd1 : 32'd0);
    end
    chk("press_rd_data", 32'(rd_data), 32'd4);
    cyc(3);
    valid = 1'b0;
    cyc(8);
    chk("press_one_entry", 32'(count), 32'd1);
    pop1();
    chk("press_pop_empty", 32'(empty), 32'd1);
    chk("press_pop_rd_data", 32'(rd_data), 32'd0);

    // Glitch of 3 samples is rejected.
    valid = 1'b1; cyc(3);
    valid = 1'b0; cyc(10);
    chk("glitch_count", 32'(count), 32'd0);

    // Bounce 1,1,0,1,1,1,1,1: push lands 6 edges after the last rising sample.
    pat = '{1, 1, 0, 1, 1, 1, 1, 1};
    din = 5'd17;
    for (int i = 0; i < 8; i++) begin
      valid = pat[i];
      @(negedge clk);
    end
    valid = 1'b0;
    cyc(1);
    chk("bounce_E8_count", 32'(count), 32'd0);
    cyc(1);
    chk("bounce_E9_count", 32'(count), 32'd1);
    cyc(8);
    chk("bounce_single_push", 32'(count), 32'd1);
    chk("bounce_rd_data", 32'(rd_data), 32'd17);
    pop1();

    // Fill / overflow / drain / clear as a vector table.
    vt.push_back(mk(OP_PRESS, 5'd1, 1, 0, 0, 5'd1));
    vt.push_back(mk(OP_PRESS, 5'd2, 2, 0, 0, 5'd1));
    vt.push_back(mk(OP_PRESS, 5'd3, 3, 0, 0, 5'd1));
    vt.push_back(mk(OP_PRESS, 5'd4, 4, 1, 0, 5'd1));
    vt.push_back(mk(OP_PRESS, 5'd5, 4, 1, 1, 5'd1));
    vt.push_back(mk(OP_POP,   5'd0, 3, 0, 1, 5'd2));
    vt.push_back(mk(OP_POP,   5'd0, 2, 0, 1, 5'd3));
    vt.push_back(mk(OP_POP,   5'd0, 1, 0, 1, 5'd4));
    vt.push_back(mk(OP_POP,   5'd0, 0, 0, 1, 5'd0));
    vt.push_back(mk(OP_CLR,   5'd0, 0, 0, 0, 5'd0));
    vt.push_back(mk(OP_PRESS, 5'd7, 1, 0, 0, 5'd7));
    vt.push_back(mk(OP_POP,   5'd0, 0, 0, 0, 5'd0));
    vt.push_back(mk(OP_POP,   5'd0, 0, 0, 0, 5'd0));
    foreach (vt[i]) begin
      case (vt[i].op)
        OP_PRESS: press(vt[i].data);
        OP_POP:   pop1();
        default:  clr1();
      endcase
      chk_all($sformatf("vec%0d", i), vt[i].c, (vt[i].c == 0), vt[i].f, vt[i].o, vt[i].r);
    end

    // Full FIFO, rd_en on the push edge: both accepted, no overflow.
    press(5'd1); press(5'd2); press(5'd3); press(5'd4);
    din = 5'd9; valid = 1'b1;
    cyc(6);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    chk_all("full_pushpop", 4, 0, 1, 0, 5'd2);
    cyc(1); valid = 1'b0; cyc(8);
    heads = '{5'd2, 5'd3, 5'd4, 5'd9};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_pushpop_drain%0d", i), 32'(rd_data), 32'(heads[i]));
      pop1();
    end
    chk("full_pushpop_drained", 32'(empty), 32'd1);

    // Empty FIFO, rd_en on the push edge: pop ignored, count becomes 1.
    din = 5'd11; valid = 1'b1;
    cyc(6);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    chk_all("empty_pushpop", 1, 0, 0, 0, 5'd11);
    cyc(1); valid = 1'b0; cyc(8);
    pop1();

    // clr_ovf on the same edge as an overflow drop: overflow still sets.
    press(5'd1); press(5'd2); press(5'd3); press(5'd4);
    din = 5'd13; valid = 1'b1;
    cyc(6);
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    chk_all("ovf_vs_clr", 4, 0, 1, 1, 5'd1);
    cyc(1); valid = 1'b0; cyc(8);
    clr1();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Reset mid-debounce with a full FIFO, valid held across reset.
    din = 5'd6; valid = 1'b1;
    cyc(3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all("async_rst", 0, 1, 0, 0, '0);
    @(negedge clk);
    chk("rst_held_count", 32'(count), 32'd0);
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_lat_F%0d", k), 32'(count), (k >= 6) ? 32'd1 : 32'd0);
    end
    valid = 1'b0; cyc(8);
    chk("post_rst_rd_data", 32'(rd_data), 32'd6);
    pop1();

    // Randomized stimulus against the reference model.
    begin
      int run = 0;
      int rd_mod;
      for (int i = 0; i < 2000; i++) begin
        chk("rand_count", 32'(count), 32'(mq.size()));
        chk("rand_empty", 32'(empty), 32'(mq.size() == 0));
        chk("rand_full", 32'(full), 32'(mq.size() == D));
        chk("rand_overflow", 32'(overflow), 32'(m_ovf));
        chk("rand_rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        if (run == 0) begin
          valid = ~valid;
          run = $urandom_range(1, 12);
        end
        run--;
        if ($urandom_range(0, 7) == 0) din = W'($urandom);
        rd_mod  = (i < 1000) ? 15 : 2;
        rd_en   = ($urandom_range(0, rd_mod) == 0);
        clr_ovf = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
